// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int ITER_W     = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_seq_fsm.sv
// Control for the shift-add multiplier: sequencing, Counter handshake, iteration
// tracking and K cross-check.
module mult_seq_fsm
  import mult_pkg::*;
#(
  parameter int WIDTH     = MULT_WIDTH,
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic k,
  output logic load,
  output logic busy,
  output logic done,
  output logic err,
  output logic start_acc,
  output logic run_en,
  output logic last_iter
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          err_q, err_d;
  logic          hold_q, hold_d;
  logic          at_last;

  assign at_last = (iter_q == ITER_LAST);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          err_d   = 1'b0;
          hold_d  = 1'b0;
        end
      end
      INIT: begin
        iter_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        iter_d = iter_q + 1'b1;
        // K and the internal count must agree; either one ends the loop so a
        // misbehaving Counter can never hang the multiplier.
        if (k != at_last) err_d = 1'b1;
        if (k || at_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        hold_d  = DONE_HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign load      = (state_q == INIT);
  assign busy      = (state_q == INIT) || (state_q == RUN);
  assign done      = (state_q == DONE) || hold_q;
  assign err       = err_q;
  assign start_acc = (state_q == IDLE) && start;
  assign run_en    = (state_q == RUN);
  assign last_iter = run_en && (k || at_last);

endmodule

// File: rtl/mult_seq_core.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Drives Load to an external Counter and ends the loop on its K flag.
module mult_seq_core
  import mult_pkg::*;
#(
  parameter int WIDTH     = MULT_WIDTH,
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  input  logic               K,
  output logic               Load,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [2*WIDTH-1:0] Product
);

  logic                 start_acc, run_en, last_iter;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;

  mult_seq_fsm #(
    .WIDTH     (WIDTH),
    .DONE_HOLD (DONE_HOLD)
  ) u_fsm (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .start     (Start),
    .k         (K),
    .load      (Load),
    .busy      (Busy),
    .done      (Done),
    .err       (Err),
    .start_acc (start_acc),
    .run_en    (run_en),
    .last_iter (last_iter)
  );

  always_comb begin
    // Carry is kept so (2^W-1)^2 shifts its top bit into P[2W-1].
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
        + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    mcand_d   = mcand_q;
    p_d       = p_q;
    product_d = product_q;
    if (start_acc) begin
      mcand_d = Multiplicand;
      p_d     = {{WIDTH{1'b0}}, Multiplier};
    end else if (run_en) begin
      p_d = {sum, p_q[WIDTH-1:1]};
    end
    // Capture on the final step so Product is valid together with Done.
    if (last_iter) product_d = p_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mcand_q   <= '0;
      p_q       <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      product_q <= product_d;
    end
  end

  assign Product = product_q;

endmodule

// File: tb/tb_mult_seq_core.sv
// Bench for mult_seq_core with a behavioural Counter and a closed-form product model.
module tb_mult_seq_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic         k;
  logic         load, busy, done, err;
  logic         load_h, busy_h, done_h, err_h;
  logic [2*W-1:0] product, product_h;

  int cnt = 0;
  int k_mode = 0;   // 0: real Counter, 1: K tied 0, 2: K forced at count 5
  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  // External Counter: cleared by Load, otherwise counts modulo W.
  always @(posedge clk) begin
    if (load) cnt <= 0;
    else      cnt <= (cnt + 1) % W;
  end

  always_comb begin
    case (k_mode)
      1:       k = 1'b0;
      2:       k = (cnt == 5);
      default: k = (cnt == W - 1);
    endcase
  end

  mult_seq_core #(.WIDTH(W), .DONE_HOLD(1'b0)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Multiplicand(mcand),
    .Multiplier(mplier), .K(k), .Load(load), .Busy(busy), .Done(done),
    .Err(err), .Product(product)
  );

  mult_seq_core #(.WIDTH(W), .DONE_HOLD(1'b1)) dut_h (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Multiplicand(mcand),
    .Multiplier(mplier), .K(k), .Load(load_h), .Busy(busy_h), .Done(done_h),
    .Err(err_h), .Product(product_h)
  );

  // Value held after n shift-add steps: the low n multiplier bits have been
  // accumulated and the unused multiplier bits remain at the bottom.
  function automatic logic [63:0] ref_prod(input logic [31:0] mc, input logic [31:0] mp,
                                           input int n);
    logic [63:0] lo_bits, acc;
    lo_bits = (n >= 32) ? {32'd0, mp} : ({32'd0, mp} & ((64'd1 << n) - 64'd1));
    acc     = ({32'd0, mc} * lo_bits) << (32 - n);
    return acc + ({32'd0, mp} >> n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; edges counts clock edges after the Start edge until Done.
  task automatic run_op(input logic [31:0] mc, input logic [31:0] mp, input bit hold_start,
                        input logic [31:0] nmc, input logic [31:0] nmp,
                        output int edges, output int loads, output logic err0);
    mcand  = mc;
    mplier = mp;
    start  = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    mcand  = nmc;
    mplier = nmp;
    err0   = err;
    edges  = 0;
    loads  = int'(load);
    for (int i = 0; i < 100; i++) begin
      step();
      edges++;
      loads += int'(load);
      if (done) break;
    end
    if (!done) edges = -1;
  endtask

  task automatic test_reset();
    #5;
    n_cmp++; if ({load, busy, done, err} !== 4'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0000", {load, busy, done, err}); end
    n_cmp++; if (product !== '0) begin n_bad++;
      $display("FAIL reset_product: got %h expected 0", product); end
    n_cmp++; if ({done_h, product_h} !== '0) begin n_bad++;
      $display("FAIL reset_hold_dut: done_h %b product_h %h expected 0", done_h, product_h); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int e, l; logic e0;
    run_op(32'd3, 32'd5, 1'b0, $urandom, $urandom, e, l, e0);
    n_cmp++; if (e !== 33) begin n_bad++;
      $display("FAIL basic_latency: got %0d edges expected 33", e); end
    n_cmp++; if (l !== 1) begin n_bad++;
      $display("FAIL basic_load_cycles: got %0d expected 1", l); end
    n_cmp++; if (product !== 64'd15) begin n_bad++;
      $display("FAIL basic_product: got %h expected %h", product, 64'd15); end
    n_cmp++; if (err !== 1'b0) begin n_bad++;
      $display("FAIL basic_err: got %b expected 0", err); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++;
      $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_cmp++; if (product !== 64'd15) begin n_bad++;
      $display("FAIL basic_product_held: got %h expected %h", product, 64'd15); end
  endtask

  task automatic test_corners();
    logic [31:0] tmc [6] = '{32'hFFFFFFFF, 32'h0, 32'h12345678, 32'hFFFFFFFF, 32'h1, 32'h80000000};
    logic [31:0] tmp [6] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h2};
    logic [63:0] exp_p;
    int e, l; logic e0;
    for (int i = 0; i < 6; i++) begin
      run_op(tmc[i], tmp[i], 1'b0, $urandom, $urandom, e, l, e0);
      exp_p = (i == 0) ? 64'hFFFFFFFE00000001 : ref_prod(tmc[i], tmp[i], 32);
      n_cmp++; if (product !== exp_p || e !== 33) begin n_bad++;
        $display("FAIL corner_%0d: got %h after %0d edges expected %h after 33",
                 i, product, e, exp_p); end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int e, l; logic e0;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = a >> $urandom_range(31, 0);
      run_op(a, b, 1'b0, $urandom, $urandom, e, l, e0);
      n_cmp++; if (product !== ref_prod(a, b, 32) || err !== 1'b0) begin n_bad++;
        $display("FAIL random_%0d: %h*%h got %h err %b expected %h err 0",
                 i, a, b, product, err, ref_prod(a, b, 32)); end
      repeat ($urandom_range(2, 0)) step();
      step();
    end
  endtask

  task automatic test_start_held();
    logic [31:0] a1, b1, a2, b2;
    int e, l; logic e0;
    bit seen;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    run_op(a1, b1, 1'b1, a2, b2, e, l, e0);
    n_cmp++; if (product !== ref_prod(a1, b1, 32) || e !== 33) begin n_bad++;
      $display("FAIL held_first: got %h after %0d edges expected %h after 33",
               product, e, ref_prod(a1, b1, 32)); end
    n_cmp++; if (l !== 1) begin n_bad++;
      $display("FAIL held_load_cycles: got %0d expected 1", l); end
    step();
    n_cmp++; if ({busy, load, done} !== 3'b000) begin n_bad++;
      $display("FAIL held_idle_gap: busy/load/done %b expected 000", {busy, load, done}); end
    step();
    n_cmp++; if ({busy, load} !== 2'b11) begin n_bad++;
      $display("FAIL held_restart: busy/load %b expected 11", {busy, load}); end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    n_cmp++; if (!seen || product !== ref_prod(a2, b2, 32)) begin n_bad++;
      $display("FAIL held_second: done %b got %h expected %h", seen, product,
               ref_prod(a2, b2, 32)); end
    step();
  endtask

  task automatic test_reset_mid();
    int e, l; logic e0;
    mcand = 32'd123; mplier = 32'd456; start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({load, busy, done, err} !== 4'b0 || product !== '0) begin n_bad++;
      $display("FAIL midreset_outputs: ctrl %b product %h expected 0",
               {load, busy, done, err}, product); end
    n_cmp++; if ({done_h, product_h} !== '0) begin n_bad++;
      $display("FAIL midreset_hold_dut: done_h %b product_h %h expected 0", done_h, product_h); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(32'd7, 32'd9, 1'b0, $urandom, $urandom, e, l, e0);
    n_cmp++; if (product !== 64'd63 || err !== 1'b0 || e !== 33) begin n_bad++;
      $display("FAIL midreset_followup: got %h err %b after %0d edges expected 63 err 0 after 33",
               product, err, e); end
    step();
  endtask

  task automatic test_k_protocol();
    logic [31:0] a, b;
    int e, l; logic e0;
    a = $urandom; b = $urandom;
    k_mode = 2;
    run_op(a, b, 1'b0, $urandom, $urandom, e, l, e0);
    n_cmp++; if (e !== 7 || err !== 1'b1) begin n_bad++;
      $display("FAIL k_early: done after %0d edges err %b expected 7 edges err 1", e, err); end
    n_cmp++; if (product !== ref_prod(a, b, 6)) begin n_bad++;
      $display("FAIL k_early_partial: got %h expected %h", product, ref_prod(a, b, 6)); end
    repeat (3) step();
    n_cmp++; if (err !== 1'b1) begin n_bad++;
      $display("FAIL k_err_sticky: got %b expected 1", err); end
    k_mode = 1;
    a = $urandom; b = $urandom;
    run_op(a, b, 1'b0, $urandom, $urandom, e, l, e0);
    n_cmp++; if (e0 !== 1'b0) begin n_bad++;
      $display("FAIL k_err_clear_on_start: got %b expected 0", e0); end
    n_cmp++; if (e !== 33 || err !== 1'b1 || product !== ref_prod(a, b, 32)) begin n_bad++;
      $display("FAIL k_missing: %0d edges err %b product %h expected 33 edges err 1 product %h",
               e, err, product, ref_prod(a, b, 32)); end
    step();
    k_mode = 0;
    run_op(32'd11, 32'd13, 1'b0, $urandom, $urandom, e, l, e0);
    n_cmp++; if (err !== 1'b0 || product !== 64'd143) begin n_bad++;
      $display("FAIL k_recover: err %b product %h expected err 0 product 143", err, product); end
    step();
  endtask

  task automatic test_done_hold();
    logic [31:0] a, b;
    int e, l; logic e0;
    a = $urandom; b = $urandom;
    run_op(a, b, 1'b0, $urandom, $urandom, e, l, e0);
    n_cmp++; if (done_h !== 1'b1 || product_h !== ref_prod(a, b, 32)) begin n_bad++;
      $display("FAIL hold_done_edge: done_h %b product_h %h expected 1 %h",
               done_h, product_h, ref_prod(a, b, 32)); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (done_h !== 1'b1 || done !== 1'b0 || product_h !== ref_prod(a, b, 32)) begin
        n_bad++;
        $display("FAIL hold_idle_%0d: done_h %b done %b product_h %h expected 1 0 %h",
                 i, done_h, done, product_h, ref_prod(a, b, 32)); end
    end
    mcand = $urandom; mplier = $urandom; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (done_h !== 1'b0 || product_h !== ref_prod(a, b, 32)) begin n_bad++;
      $display("FAIL hold_release: done_h %b product_h %h expected 0 %h",
               done_h, product_h, ref_prod(a, b, 32)); end
    repeat (40) step();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_held();
    test_reset_mid();
    test_k_protocol();
    test_done_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
